// File: rtl/exp4_unidade_controle.sv
// Control unit for the memory-match game: a Moore FSM that sequences the
// datapath through one round and aborts the round if a play takes too long.
module exp4_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [TW-1:0]   timer_q, timer_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // Timer only runs in espera and saturates so it can never wrap.
    always_comb begin
        timer_d = '0;
        if (estado_q == ESPERA) begin
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:     if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:  estado_d = ESPERA;
            // A play arriving on the last timer cycle takes priority over the timeout.
            ESPERA: begin
                if (jogada)                  estado_d = REGISTRA;
                else if (timer_q == TIMER_MAX) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:    estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    estado_d = FIM_ERRO;
                else if (fimC) estado_d = FIM_ACERTO;
                else           estado_d = PROXIMO;
            end
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                         if (iniciar) estado_d = PREPARACAO;
            default:     estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            PREPARACAO:  begin zeraC = 1'b1; zeraR = 1'b1; end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTO:  begin pronto = 1'b1; acertou = 1'b1; end
            FIM_ERRO:    begin pronto = 1'b1; errou = 1'b1; end
            FIM_TIMEOUT: begin pronto = 1'b1; errou = 1'b1; timeout = 1'b1; end
            default:     ;
        endcase
    end

    assign db_estado = estado_q;

endmodule
